// File: rtl/ifetch_buf_pkg.sv
// Shared types and geometry for the instruction-fetch line buffer.
// A line is 32 bytes, delivered as four 64-bit little-endian beats.
package ifetch_buf_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = 4;
  localparam int LINE_W     = BEAT_W * BEATS;
  localparam int OFFSET_W   = 5;
  localparam int TAG_W      = ADDR_W - OFFSET_W;
  localparam int BEAT_IDX_W = 2;
  localparam int WORD_IDX_W = OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } ifetch_state_t;

  // Odd words live in the upper half of their beat.
  function automatic logic [DATA_W-1:0] beat_word(input logic [BEAT_W-1:0] beat,
                                                  input logic            hi);
    return hi ? beat[BEAT_W-1:DATA_W] : beat[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/ifetch_line_buffer_if.sv
// Fetch-side and physical-memory-side signals of the line buffer, bundled.
// Slave modport is the buffer's view; master modport is the environment's view.
interface ifetch_line_buffer_if;
  import ifetch_buf_pkg::*;

  // Fetch port: mem_read is a request held (with mem_address) until the
  // single-cycle mem_resp pulse; mem_rdata is meaningful only while mem_resp=1.
  // Burst port: pmem_read stays high for the whole burst with a stable
  // pmem_address; each pmem_resp=1 cycle transfers exactly one beat.
  logic                mem_read;
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_resp;
  logic                flush;
  logic                pmem_read;
  logic [ADDR_W-1:0]   pmem_address;
  logic [BEAT_W-1:0]   pmem_rdata;
  logic                pmem_resp;
  ifetch_state_t       dbg_state;

  modport slave (
    input  mem_read, mem_address, flush, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_address, dbg_state
  );

  modport master (
    output mem_read, mem_address, flush, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_address, dbg_state
  );

endinterface

// File: rtl/ifetch_line_store.sv
// Storage for the single buffered line: four beats, the line tag and its valid bit.
// Line data is deliberately left unreset; valid gates every use of it.
module ifetch_line_store
  import ifetch_buf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_we_i,
  input  logic [BEAT_IDX_W-1:0] beat_idx_i,
  input  logic [BEAT_W-1:0]     beat_data_i,
  input  logic                  tag_we_i,
  input  logic [TAG_W-1:0]      tag_d_i,
  input  logic                  valid_we_i,
  input  logic                  valid_d_i,
  input  logic [WORD_IDX_W-1:0] rd_word_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic                  valid_o
);

  logic [BEAT_W-1:0] line_q [BEATS];
  logic [TAG_W-1:0]  tag_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (beat_we_i) begin
      line_q[beat_idx_i] <= beat_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (tag_we_i) begin
        tag_q <= tag_d_i;
      end
      if (valid_we_i) begin
        valid_q <= valid_d_i;
      end
    end
  end

  assign rd_data_o = beat_word(line_q[rd_word_i[WORD_IDX_W-1:1]], rd_word_i[0]);
  assign tag_o     = tag_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction fetch buffer: answers hits from the held line and
// refills it with a 4-beat burst on a miss or after a flush.
module ifetch_line_buffer
  import ifetch_buf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  ifetch_line_buffer_if.slave bus
);

  ifetch_state_t         state_q, state_d;
  logic [TAG_W-1:0]      line_addr_q, line_addr_d;
  logic [WORD_IDX_W-1:0] word_q, word_d;
  logic [BEAT_IDX_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic                  beat_we;
  logic                  tag_we;
  logic                  valid_we;
  logic                  valid_d;
  logic [WORD_IDX_W-1:0] rd_word;
  logic [DATA_W-1:0]     st_rdata;
  logic [TAG_W-1:0]      st_tag;
  logic                  st_valid;

  logic [TAG_W-1:0]      req_tag;
  logic [WORD_IDX_W-1:0] req_word;
  logic                  hit;
  logic                  last_beat;
  logic                  unused_addr_lsb;

  assign req_tag         = bus.mem_address[ADDR_W-1:OFFSET_W];
  assign req_word        = bus.mem_address[OFFSET_W-1:2];
  assign unused_addr_lsb = ^bus.mem_address[1:0];
  assign hit             = st_valid && (st_tag == req_tag);
  assign last_beat       = (beat_cnt_q == BEAT_IDX_W'(BEATS - 1));

  // During a fill the read port points at the latched word so the final beat
  // can merge with the three beats already stored.
  assign rd_word = (state_q == BURST) ? word_q : req_word;

  ifetch_line_store u_store (
    .clk         (clk),
    .rst         (rst),
    .beat_we_i   (beat_we && !rst),
    .beat_idx_i  (beat_cnt_q),
    .beat_data_i (bus.pmem_rdata),
    .tag_we_i    (tag_we),
    .tag_d_i     (line_addr_q),
    .valid_we_i  (valid_we),
    .valid_d_i   (valid_d),
    .rd_word_i   (rd_word),
    .rd_data_o   (st_rdata),
    .tag_o       (st_tag),
    .valid_o     (st_valid)
  );

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    word_d       = word_q;
    beat_cnt_d   = beat_cnt_q;
    flush_pend_d = flush_pend_q;
    rdata_d      = rdata_q;
    beat_we      = 1'b0;
    tag_we       = 1'b0;
    valid_we     = 1'b0;
    valid_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          valid_we = 1'b1;
        end
        if (bus.mem_read) begin
          if (hit && !bus.flush) begin
            rdata_d = st_rdata;
            state_d = RESP;
          end else begin
            line_addr_d  = req_tag;
            word_d       = req_word;
            beat_cnt_d   = '0;
            flush_pend_d = 1'b0;
            state_d      = BURST;
          end
        end
      end

      BURST: begin
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end
        if (bus.pmem_resp) begin
          beat_we    = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            tag_we   = 1'b1;
            valid_we = 1'b1;
            valid_d  = !(flush_pend_q || bus.flush);
            // The requested word may sit in the beat arriving right now.
            rdata_d  = (word_q[WORD_IDX_W-1:1] == beat_cnt_q)
                       ? beat_word(bus.pmem_rdata, word_q[0])
                       : st_rdata;
            state_d  = RESP;
          end
        end
      end

      RESP: begin
        if (bus.flush) begin
          valid_we = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      line_addr_q  <= '0;
      word_q       <= '0;
      beat_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      word_q       <= word_d;
      beat_cnt_q   <= beat_cnt_d;
      flush_pend_q <= flush_pend_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.pmem_read    = (state_q == BURST);
  assign bus.pmem_address = {line_addr_q, {OFFSET_W{1'b0}}};
  assign bus.mem_resp     = (state_q == RESP);
  assign bus.mem_rdata    = rdata_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Self-checking bench for ifetch_line_buffer: directed table, corner
// sequences (mid-burst flush, mid-burst reset) and randomized fetches.
module tb_ifetch_line_buffer;
  import ifetch_buf_pkg::*;

  logic clk;
  logic rst;
  ifetch_line_buffer_if bus();

  ifetch_line_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  // burst-memory responder state
  int          bursts    = 0;
  int          gaps_used = 0;
  int          beat_k    = 0;
  int          gap_left  = 0;
  int          first_gap = 1;
  int          gap_min   = 0;
  int          gap_max   = 0;
  bit          rd_seen   = 0;
  logic [31:0] last_paddr = '0;

  // reference model: one line, tagged by address bits [31:5]
  bit          m_valid = 0;
  logic [26:0] m_line  = '0;

  typedef struct {
    logic [31:0] addr;
    logic        fl;
    logic        exp_burst;
    logic [31:0] exp_paddr;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;
  vec_t vecs[10];

  // ---------------- memory contents ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0068) return 32'h0000_0013;
    if (a == 32'h0000_006C) return 32'h1111_1111;
    return {a[31:16] ^ 16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [63:0] mem_beat(input logic [31:0] b);
    return {mem_word(b + 32'd4), mem_word(b)};
  endfunction

  // ---------------- protocol monitor ----------------
  logic [31:0] held_addr;
  bit          held = 0;
  always @(posedge clk) begin
    if (bus.mem_read && held)
      assert (bus.mem_address == held_addr)
        else $error("FAIL addr_hold: address changed to 0x%0h while 0x%0h pending", bus.mem_address, held_addr);
    held      <= bus.mem_read && !bus.mem_resp;
    held_addr <= bus.mem_address;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One negedge step of the burst memory.
  task automatic mem_step();
    bus.pmem_resp = 1'b0;
    if (!bus.pmem_read) begin
      rd_seen = 0;
    end else begin
      if (!rd_seen) begin
        rd_seen    = 1;
        beat_k     = 0;
        gap_left   = first_gap;
        bursts++;
        last_paddr = bus.pmem_address;
      end
      if (beat_k < BEATS) begin
        if (gap_left > 0) begin
          gap_left--;
          gaps_used++;
        end else begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = mem_beat(last_paddr + 32'(beat_k * 8));
          beat_k++;
          gap_left = $urandom_range(gap_max, gap_min);
        end
      end
    end
  endtask

  task automatic run_fetch(input logic [31:0] addr, input logic fl, input int flush_beat,
                           output bit ok, output logic [31:0] data, output int lat,
                           output int nburst, output int ngap, output bit mid_flush);
    int b0, g0;
    b0 = bursts; g0 = gaps_used;
    ok = 0; lat = 0; mid_flush = 0; data = '0;
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = addr;
    bus.flush       = fl;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      lat++;
      bus.flush = 1'b0;
      mem_step();
      if (flush_beat >= 0 && bus.pmem_resp && (beat_k - 1) == flush_beat) begin
        bus.flush = 1'b1;
        mid_flush = 1;
      end
      if (bus.mem_resp) begin
        ok   = 1;
        data = bus.mem_rdata;
        break;
      end
    end
    bus.mem_read = 1'b0;
    bus.flush    = 1'b0;
    nburst = bursts - b0;
    ngap   = gaps_used - g0;
  endtask

  function automatic void model_commit(input logic [31:0] addr, input logic fl, input bit mid_flush);
    if (!(m_valid && m_line == addr[31:5] && !fl)) begin
      m_line  = addr[31:5];
      m_valid = !mid_flush;
    end
  endfunction

  // Fetch checked against the reference model and scoreboard.
  task automatic model_fetch(input logic [31:0] addr, input logic fl, input int flush_beat, input string tag);
    bit exp_hit, ok, mid;
    logic [31:0] data;
    int lat, nb, ng;
    exp_hit = m_valid && (m_line == addr[31:5]) && !fl;
    exp_q.push_back(mem_word({addr[31:2], 2'b00}));
    run_fetch(addr, fl, flush_beat, ok, data, lat, nb, ng, mid);
    check({tag, " resp"}, 64'(ok), 64'd1);
    check({tag, " data"}, 64'(data), 64'(exp_q.pop_front()));
    check({tag, " bursts"}, 64'(nb), exp_hit ? 64'd0 : 64'd1);
    check({tag, " latency"}, 64'(lat), exp_hit ? 64'd1 : 64'(5 + ng));
    if (!exp_hit) check({tag, " pmem_address"}, 64'(last_paddr), 64'({addr[31:5], 5'b0}));
    model_commit(addr, fl, mid);
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [31:0] lines[4];
    bit ok, mid;
    logic [31:0] data;
    int lat, nb, ng;

    vecs[0] = '{32'h0000_0060, 1'b0, 1'b1, 32'h0000_0060, 32'hC0DE_0060, 6};
    vecs[1] = '{32'h0000_0064, 1'b0, 1'b0, 32'h0000_0060, 32'hC0DE_0064, 1};
    vecs[2] = '{32'h0000_006C, 1'b0, 1'b0, 32'h0000_0060, 32'h1111_1111, 1};
    vecs[3] = '{32'h0000_0068, 1'b0, 1'b0, 32'h0000_0060, 32'h0000_0013, 1};
    vecs[4] = '{32'h0000_007C, 1'b0, 1'b0, 32'h0000_0060, 32'hC0DE_007C, 1};
    vecs[5] = '{32'h0000_0080, 1'b0, 1'b1, 32'h0000_0080, 32'hC0DE_0080, 6};
    vecs[6] = '{32'h0000_009C, 1'b0, 1'b0, 32'h0000_0080, 32'hC0DE_009C, 1};
    vecs[7] = '{32'h0000_0060, 1'b0, 1'b1, 32'h0000_0060, 32'hC0DE_0060, 6};
    vecs[8] = '{32'h0000_0078, 1'b1, 1'b1, 32'h0000_0060, 32'hC0DE_0078, 6};
    vecs[9] = '{32'h0000_0070, 1'b0, 1'b0, 32'h0000_0060, 32'hC0DE_0070, 1};

    rst             = 1'b1;
    bus.mem_read    = 1'b0;
    bus.mem_address = '0;
    bus.flush       = 1'b0;
    bus.pmem_rdata  = '0;
    bus.pmem_resp   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset mem_resp", 64'(bus.mem_resp), 64'd0);
    check("reset mem_rdata", 64'(bus.mem_rdata), 64'd0);
    check("reset pmem_read", 64'(bus.pmem_read), 64'd0);
    check("reset pmem_address", 64'(bus.pmem_address), 64'd0);
    check("reset state", 64'(bus.dbg_state), 64'(IDLE));

    // directed table: cold miss, hits on both halves of beats, replacement, flush+read
    first_gap = 1; gap_min = 0; gap_max = 0;
    for (int i = 0; i < 10; i++) begin
      run_fetch(vecs[i].addr, vecs[i].fl, -1, ok, data, lat, nb, ng, mid);
      check($sformatf("vec%0d resp", i), 64'(ok), 64'd1);
      check($sformatf("vec%0d data", i), 64'(data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d bursts", i), 64'(nb), 64'(vecs[i].exp_burst));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d pmem_address", i), 64'(last_paddr), 64'(vecs[i].exp_paddr));
      model_commit(vecs[i].addr, vecs[i].fl, mid);
    end

    // flush during beat 2: response still delivered, line left invalid
    model_fetch(32'h0000_0100, 1'b0, 2, "flush_mid");
    model_fetch(32'h0000_0104, 1'b0, -1, "flush_refetch");
    model_fetch(32'h0000_0108, 1'b0, -1, "flush_rehit");

    // reset after beat 1 of a burst, then stray pmem_resp pulses
    @(negedge clk);
    bus.mem_read = 1'b1; bus.mem_address = 32'h0000_0200;
    @(negedge clk);
    check("rstmid pmem_read", 64'(bus.pmem_read), 64'd1);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = mem_beat(32'h0000_0200);
    @(negedge clk);
    bus.pmem_rdata = mem_beat(32'h0000_0208);
    @(negedge clk);
    bus.pmem_resp = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rstmid pmem_read after rst", 64'(bus.pmem_read), 64'd0);
    check("rstmid mem_resp after rst", 64'(bus.mem_resp), 64'd0);
    check("rstmid state after rst", 64'(bus.dbg_state), 64'(IDLE));
    rst = 1'b0; bus.mem_read = 1'b0;
    bus.pmem_resp = 1'b1; bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    check("stray pmem_read", 64'(bus.pmem_read), 64'd0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check("stray state", 64'(bus.dbg_state), 64'(IDLE));
    check("stray mem_resp", 64'(bus.mem_resp), 64'd0);
    m_valid = 0; rd_seen = 0;
    model_fetch(32'h0000_0208, 1'b0, -1, "rstmid refetch");
    model_fetch(32'h0000_0200, 1'b0, -1, "rstmid beat0");
    model_fetch(32'h0000_021C, 1'b0, -1, "rstmid beat3");

    // irregular beat spacing, then every word of the assembled line
    first_gap = 1; gap_min = 1; gap_max = 3;
    model_fetch(32'h0000_0314, 1'b0, -1, "gaps miss");
    for (int w = 0; w < 8; w++)
      model_fetch(32'h0000_0300 + 32'(w * 4), 1'b0, -1, $sformatf("gaps word%0d", w));

    // randomized traffic over a few lines
    lines[0] = 32'h0000_1000; lines[1] = 32'h0000_1020;
    lines[2] = 32'h0004_2000; lines[3] = 32'h8000_0FE0;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int op;
      first_gap = $urandom_range(0, 2);
      gap_min   = 0;
      gap_max   = $urandom_range(0, 3);
      a  = lines[$urandom_range(0, 3)] | 32'($urandom_range(0, 7) * 4);
      op = $urandom_range(0, 9);
      if (op == 0) begin
        @(negedge clk); bus.flush = 1'b1;
        @(negedge clk); bus.flush = 1'b0;
        m_valid = 0;
      end else if (op == 1) begin
        model_fetch(a, 1'b1, -1, $sformatf("rnd%0d flushreq", n));
      end else if (op == 2) begin
        model_fetch(a, 1'b0, $urandom_range(0, 3), $sformatf("rnd%0d flushmid", n));
      end else begin
        model_fetch(a, 1'b0, -1, $sformatf("rnd%0d", n));
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
